oc8051_int_sched: RTL and testbench
===================================

// Module: oc8051_int_sched
// PURPOSE
//  Interrupt scheduler feeding the instruction-select stage's intr/int_v inputs.
//  Masks the six interrupt source flags with IE and splits them into two priority levels with IP.
//  Tracks the in-service level, issues one LCALL request at a time and clears the serviced flag on ack.
//  Retires the in-service level on RETI. Sits between the SFR/timer/UART flag logic and instruction select.
// PARAMETERS
//  SRC_N     6      number of interrupt sources (index 0 = highest natural priority)
//  VEC_BASE  8'h03  vector low byte of source 0
//  VEC_STEP  8'h08  vector spacing between consecutive sources
// PORTS
//  clk      in   1      clock
//  rst      in   1      reset, synchronous, active-high
//  src_req  in   SRC_N  pending flags (IE0,TF0,IE1,TF1,RI|TI,TF2), level-sensitive
//  ie       in   8      IE SFR: bit7 EA global enable, bits[SRC_N-1:0] per-source enable
//  ip       in   SRC_N  IP SFR: 1 = high priority level
//  rd       in   1      instruction-fetch boundary strobe from decoder
//  reti     in   1      one-cycle pulse, RETI executed
//  ack      in   1      one-cycle pulse from instruction select, LCALL injected
//  intr     out  1      one-cycle interrupt request to instruction select
//  int_v    out  8      vector low byte; valid in intr cycle, held until next intr
//  src_clr  out  SRC_N  one-hot one-cycle clear of the serviced source flag
//  isr_lvl  out  2      in-service levels: [1] high active, [0] low active
// BEHAVIOUR
//  Reset (sync): state=IDLE, intr=0, int_v=8'h00, src_clr=0, isr_lvl=2'b00, holdoff=0, sel_idx=0.
//  Masking and eligibility:
//  - pend = src_req & ie[SRC_N-1:0] & {SRC_N{ie[7]}}
//  - hi_ok = |(pend & ip) & !isr_lvl[1]
//  - lo_ok = |(pend & ~ip) & !isr_lvl[1] & !isr_lvl[0]
//  - Winner: lowest index among high-level pend if hi_ok, else lowest index among low-level pend.
//  Hold-off: a reti pulse sets holdoff=1; the next rd clears it. No request is issued while holdoff=1
//    (guarantees one instruction executes after RETI).
//  FSM states IDLE, WAIT_ACK; all outputs registered.
//  - IDLE: if (hi_ok|lo_ok) & !holdoff & !reti:
//    - next cycle: intr=1, int_v=VEC_BASE+VEC_STEP*idx (8-bit wrap)
//    - latch sel_idx and sel_lvl; state -> WAIT_ACK
//    - latency: 1 clk from eligible to intr.
//  - WAIT_ACK: intr=0. No new request, even if a higher source arrives.
//    - On ack: isr_lvl[sel_lvl] <= 1; next cycle src_clr[sel_idx]=1 for exactly one clk; state -> IDLE.
//    - Committed once intr is issued: withdrawal of src_req or IE/IP changes do not cancel it.
//  - IDLE after ack: re-evaluation starts the cycle after src_clr, so a cleared flag is not re-issued.
//  RETI handling, any state: clears isr_lvl[1] if set, else isr_lvl[0]; no effect if 2'b00.
//  Simultaneous events:
//  - reti & ack in the same clk: the clear applies to the pre-ack isr_lvl, then the ack set is ORed in.
//  - ack in IDLE: ignored.
//  - rst mid-WAIT_ACK: returns to IDLE, isr_lvl cleared, no src_clr pulse.
//  Preemption: high-level request allowed while only isr_lvl[0] set; never while isr_lvl[1] set.
//  All SRC_N flags pending with equal level: strictly index order across successive services.
// TESTING
//  1 rst=1 for 2 clk with src_req=6'h3F, ie=8'hFF -> intr=0, int_v=8'h00, src_clr=0, isr_lvl=0.
//  2 ie=8'h81, ip=0, src_req=6'h01 -> intr 1 clk later, int_v=8'h03.
//    ack -> src_clr=6'h01 one clk, isr_lvl=2'b01.
//  3 ie=8'h8F, src_req=6'h0A, ip=6'h08 -> int_v=8'h1B (TF1, high) first.
//    After ack, no further intr (low blocked by isr_lvl[1]).
//  4 isr_lvl=2'b01, src_req=6'h04 low -> no intr.
//    ip=6'h04 -> intr int_v=8'h13; after ack isr_lvl=2'b11.
//    reti -> 2'b01; second reti -> 2'b00.
//  5 reti pulse with src_req=6'h02 enabled -> no intr until rd pulses once.
//    intr int_v=8'h0B asserted 1 clk after rd.
//  6 ie=8'h01 (EA=0), src_req=6'h01 -> intr never asserted.
//    rst asserted in WAIT_ACK -> IDLE, isr_lvl=0, late ack ignored.

Source files
------------

// File: rtl/oc8051_int_sched_if.sv
// oc8051_int_sched_if: interrupt scheduler bus between flag logic, decoder and instruction select
interface oc8051_int_sched_if #(parameter int SRC_N = 6);
   logic [SRC_N-1:0] src_req, ip, src_clr;
   logic [7:0] ie, int_v;
   logic rd, reti, ack, intr;
   logic [1:0] isr_lvl;
   modport master(output src_req, ie, ip, rd, reti, ack, input intr, int_v, src_clr, isr_lvl);
   modport slave(input src_req, ie, ip, rd, reti, ack, output intr, int_v, src_clr, isr_lvl);
endinterface

// File: rtl/oc8051_int_sched.sv
// oc8051_int_sched: two-level interrupt scheduler issuing one LCALL request at a time
module oc8051_int_sched #(
   parameter int SRC_N = 6,
   parameter logic [7:0] VEC_BASE = 8'h03,
   parameter logic [7:0] VEC_STEP = 8'h08
) (
   input logic clk,
   input logic rst,
   oc8051_int_sched_if.slave bus
);
   localparam int IW = $clog2(SRC_N);
   typedef enum logic {IDLE, WAIT_ACK} state_t;
   state_t state;
   logic holdoff, sel_lvl, intr_q, hi_ok, lo_ok, go, ack_ok, unused_ie;
   logic [IW-1:0] sel_idx, win_idx;
   logic [7:0] int_v_q, vec;
   logic [SRC_N-1:0] src_clr_q, pend, cand;
   logic [1:0] isr_q, lvl_nxt;
   assign bus.intr = intr_q;
   assign bus.int_v = int_v_q;
   assign bus.src_clr = src_clr_q;
   assign bus.isr_lvl = isr_q;
   assign unused_ie = ^bus.ie[6:SRC_N];
   always_comb begin
      pend = bus.src_req & bus.ie[SRC_N-1:0] & {SRC_N{bus.ie[7]}};
      hi_ok = |(pend & bus.ip) & !isr_q[1];
      lo_ok = |(pend & ~bus.ip) & !(|isr_q);
      cand = hi_ok ? pend & bus.ip : pend & ~bus.ip;
      win_idx = '0;
      for (int i = SRC_N - 1; i >= 0; i--)
         if (cand[i]) win_idx = IW'(i);
      vec = VEC_BASE + VEC_STEP * 8'(win_idx);
      // the cycle showing src_clr is skipped so the flag being cleared is not re-issued
      go = (state == IDLE) & (hi_ok | lo_ok) & !(holdoff & !bus.rd) & !bus.reti & !(|src_clr_q);
      ack_ok = (state == WAIT_ACK) & bus.ack;
      lvl_nxt = (bus.reti ? (isr_q[1] ? isr_q & 2'b01 : 2'b00) : isr_q) | (ack_ok ? 2'b01 << sel_lvl : 2'b00);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         intr_q <= 1'b0;
         int_v_q <= 8'h00;
         src_clr_q <= '0;
         isr_q <= 2'b00;
         holdoff <= 1'b0;
         sel_idx <= '0;
         sel_lvl <= 1'b0;
      end else begin
         intr_q <= go;
         isr_q <= lvl_nxt;
         holdoff <= bus.reti | (holdoff & !bus.rd);
         src_clr_q <= ack_ok ? SRC_N'(1) << sel_idx : '0;
         if (go) begin
            state <= WAIT_ACK;
            sel_idx <= win_idx;
            sel_lvl <= hi_ok;
            int_v_q <= vec;
         end else if (ack_ok) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_oc8051_int_sched.sv
// tb_oc8051_int_sched: vector table, corner sequences and randomized run against a level-stack model
module tb_oc8051_int_sched;
   logic clk, rst;
   int checks = 0, failures = 0;
   oc8051_int_sched_if #(.SRC_N(6)) bus();
   oc8051_int_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic rst; logic [5:0] src; logic [7:0] ie; logic [5:0] ip; logic rd, reti, ack;
      logic e_intr; logic [7:0] e_v; logic [5:0] e_clr; logic [1:0] e_lvl;
   } vec_t;
   vec_t tv[$];

   // model: in-service levels kept as a stack of nested services, top = most recent
   int stk[$];
   logic m_intr, m_wait, m_hold, m_sel_lvl;
   logic [7:0] m_vec;
   logic [5:0] m_clr;
   int m_sel;

   function automatic logic [1:0] m_lvl();
      logic [1:0] l = 2'b00;
      foreach (stk[k]) l[stk[k]] = 1'b1;
      return l;
   endfunction

   task automatic model_step();
      logic [5:0] pend;
      int best, bs, sc;
      bit blocked, ack_eff, has_hi;
      if (rst) begin
         m_intr = 0; m_vec = 0; m_clr = 0; m_wait = 0; m_hold = 0; m_sel = 0; m_sel_lvl = 0;
         stk.delete();
         return;
      end
      pend = bus.src_req & bus.ie[5:0] & {6{bus.ie[7]}};
      has_hi = stk.size() > 0 && stk[$] == 1;
      best = -1; bs = 99;
      for (int i = 0; i < 6; i++)
         if (pend[i] && (bus.ip[i] ? !has_hi : stk.size() == 0)) begin
            sc = bus.ip[i] ? i : i + 6;
            if (sc < bs) begin bs = sc; best = i; end
         end
      blocked = m_wait || (m_hold && !bus.rd) || bus.reti || m_clr != 0;
      ack_eff = m_wait && bus.ack;
      if (bus.reti && stk.size() > 0) void'(stk.pop_back());
      m_clr = 0;
      if (ack_eff) begin stk.push_back(int'(m_sel_lvl)); m_clr = 6'(1) << m_sel; m_wait = 0; end
      m_hold = bus.reti || (m_hold && !bus.rd);
      m_intr = best >= 0 && !blocked;
      if (m_intr) begin m_wait = 1; m_sel = best; m_sel_lvl = bus.ip[best]; m_vec = 8'(3 + 8 * best); end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic r, input logic [5:0] s, input logic [7:0] e, input logic [5:0] p,
                        input logic d, input logic t, input logic a);
      rst = r; bus.src_req = s; bus.ie = e; bus.ip = p; bus.rd = d; bus.reti = t; bus.ack = a;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] s, input logic [7:0] e, input logic [5:0] p,
                      input logic d, input logic t, input logic a,
                      input logic ei, input logic [7:0] ev, input logic [5:0] ec, input logic [1:0] el);
      tv.push_back('{r, s, e, p, d, t, a, ei, ev, ec, el});
   endtask

   initial begin
      int n;
      logic [5:0] src;
      add(1,'h3F,'hFF,0,0,0,0, 0,'h00,0,0);
      add(1,'h3F,'hFF,0,0,0,0, 0,'h00,0,0);
      add(0,'h01,'h81,0,0,0,0, 1,'h03,0,0);
      add(0,'h01,'h81,0,0,0,1, 0,'h03,'h01,1);
      add(0,0,'h81,0,0,0,0, 0,'h03,0,1);
      add(0,0,'h81,0,0,1,0, 0,'h03,0,0);
      add(0,0,'h81,0,1,0,0, 0,'h03,0,0);
      add(0,'h0A,'h8F,'h08,0,0,0, 1,'h1B,0,0);
      add(0,'h0A,'h8F,'h08,0,0,1, 0,'h1B,'h08,2);
      add(0,'h02,'h8F,'h08,0,0,0, 0,'h1B,0,2);
      add(0,'h02,'h8F,'h08,0,0,0, 0,'h1B,0,2);
      add(0,'h02,'h8F,'h08,0,1,0, 0,'h1B,0,0);
      add(0,'h02,'h8F,'h08,1,0,0, 1,'h0B,0,0);
      add(0,'h02,'h8F,'h08,0,0,1, 0,'h0B,'h02,1);
      add(0,'h04,'h8F,'h08,0,0,0, 0,'h0B,0,1);
      add(0,'h04,'h8F,'h04,0,0,0, 1,'h13,0,1);
      add(0,'h04,'h8F,'h04,0,0,1, 0,'h13,'h04,3);
      add(0,0,'h8F,'h04,0,1,0, 0,'h13,0,1);
      add(0,0,'h8F,'h04,0,1,0, 0,'h13,0,0);
      add(0,'h02,'h8F,0,1,0,0, 1,'h0B,0,0);
      add(0,'h02,'h8F,0,0,0,1, 0,'h0B,'h02,1);
      add(0,'h02,'h8F,0,0,0,0, 0,'h0B,0,1);
      add(0,'h02,'h8F,0,0,1,0, 0,'h0B,0,0);
      add(0,'h02,'h8F,0,0,0,0, 0,'h0B,0,0);
      add(0,'h02,'h8F,0,0,0,0, 0,'h0B,0,0);
      add(0,'h02,'h8F,0,1,0,0, 1,'h0B,0,0);
      add(0,'h02,'h8F,0,0,0,1, 0,'h0B,'h02,1);
      add(0,0,'h8F,0,0,1,0, 0,'h0B,0,0);
      add(0,0,'h8F,0,1,0,0, 0,'h0B,0,0);
      add(0,'h01,'h01,0,0,0,0, 0,'h0B,0,0);
      add(0,'h01,'h01,0,0,0,0, 0,'h0B,0,0);
      add(0,'h01,'h81,0,0,0,0, 1,'h03,0,0);
      add(0,'h01,'h81,0,0,0,0, 0,'h03,0,0);
      add(1,'h01,'h81,0,0,0,0, 0,'h00,0,0);
      add(0,0,'h81,0,0,0,1, 0,'h00,0,0);
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      foreach (tv[k]) begin
         drive(tv[k].rst, tv[k].src, tv[k].ie, tv[k].ip, tv[k].rd, tv[k].reti, tv[k].ack);
         tick();
         chk($sformatf("tv%0d_intr", k), 32'(bus.intr), 32'(tv[k].e_intr));
         chk($sformatf("tv%0d_int_v", k), 32'(bus.int_v), 32'(tv[k].e_v));
         chk($sformatf("tv%0d_src_clr", k), 32'(bus.src_clr), 32'(tv[k].e_clr));
         chk($sformatf("tv%0d_isr_lvl", k), 32'(bus.isr_lvl), 32'(tv[k].e_lvl));
      end
      // reti and ack in the same cycle while a high service preempts a low one
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 'h01, 'h83, 'h02, 0, 0, 0); tick();
      chk("sim_low_intr", 32'(bus.intr), 1);
      drive(0, 'h01, 'h83, 'h02, 0, 0, 1); tick();
      chk("sim_low_lvl", 32'(bus.isr_lvl), 1);
      drive(0, 'h02, 'h83, 'h02, 0, 0, 0); tick();
      chk("sim_clr_gap", 32'(bus.intr), 0);
      tick();
      chk("sim_preempt_intr", 32'(bus.intr), 1);
      chk("sim_preempt_vec", 32'(bus.int_v), 'h0B);
      drive(0, 0, 'h83, 'h02, 0, 1, 1); tick();
      chk("sim_reti_ack_lvl", 32'(bus.isr_lvl), 2);
      chk("sim_reti_ack_clr", 32'(bus.src_clr), 'h02);
      // all flags pending at one level: serviced in index order
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      src = 6'h3F;
      drive(0, src, 'hBF, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (!bus.intr && n < 10) begin tick(); n++; end
         chk($sformatf("ord%0d_intr", k), 32'(bus.intr), 1);
         chk($sformatf("ord%0d_vec", k), 32'(bus.int_v), 32'(3 + 8 * k));
         bus.ack = 1; tick(); bus.ack = 0;
         chk($sformatf("ord%0d_clr", k), 32'(bus.src_clr), 32'(1 << k));
         src[k] = 1'b0; bus.src_req = src;
         bus.reti = 1; tick(); bus.reti = 0;
         bus.rd = 1; tick(); bus.rd = 0;
      end
      // randomized run against the model
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 1500; c++) begin
         drive($urandom_range(99) == 0, 6'($urandom), {$urandom_range(3) != 0, 7'($urandom)}, 6'($urandom),
               $urandom_range(9) < 3, $urandom_range(9) == 0, $urandom_range(9) < 3);
         tick();
         chk("rnd_intr", 32'(bus.intr), 32'(m_intr));
         chk("rnd_int_v", 32'(bus.int_v), 32'(m_vec));
         chk("rnd_src_clr", 32'(bus.src_clr), 32'(m_clr));
         chk("rnd_isr_lvl", 32'(bus.isr_lvl), 32'(m_lvl()));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
